uart_cmd_parser: RTL
====================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter: ADDR_WIDTH, 8, bus address width.
REQ-002 Parameter: TIMEOUT_CYCLES, 500000, maximum clk cycles allowed between bytes of one frame.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous and active-high.
REQ-005 Port: rx_data  in  8  received byte from the UART receiver.
REQ-006 Port: rx_done  in  1  one-cycle pulse; rx_data is valid in this cycle.
REQ-007 Port: tx_data  out  8  response byte to the UART transmitter.
REQ-008 Port: tx_en  out  1  one-cycle request to start transmitting tx_data.
REQ-009 Port: tx_busy  in  1  transmitter busy.
REQ-010 Port: tx_done  in  1  one-cycle pulse; transmission finished.
REQ-011 Port: mem_addr  out  ADDR_WIDTH  bus address.
REQ-012 Port: mem_wdata  out  8  bus write data.
REQ-013 Port: mem_we  out  1  one-cycle write strobe.
REQ-014 Port: mem_re  out  1  one-cycle read strobe.
REQ-015 Port: mem_rdata  in  8  read data, valid exactly 1 cycle after mem_re.
REQ-016 Port: busy  out  1  high whenever the state is not IDLE.
REQ-017 Port: err  out  1  one-cycle pulse on bad opcode, timeout, or dropped byte.

Function
REQ-018 Frame format: write = 0x57, addr, data; read = 0x52, addr. Only the low ADDR_WIDTH bits of the addr byte are used.
REQ-019 States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND, WAIT_TX.
REQ-020 IDLE transitions on rx_done:
- 0x57 or 0x52: latch the opcode, go to GET_ADDR.
- Any other byte: load tx_data=0x3F, pulse err, go to SEND.
REQ-021 GET_ADDR on rx_done: latch mem_addr; go to GET_DATA if the opcode is write, else go to BUS_RD.
REQ-022 GET_DATA on rx_done: latch mem_wdata, go to BUS_WR.
REQ-023 BUS_WR: assert mem_we for exactly 1 cycle, load tx_data=0x4B, go to SEND.
REQ-024 BUS_RD: assert mem_re for exactly 1 cycle, go to RD_WAIT.
REQ-025 RD_WAIT: capture mem_rdata into tx_data, go to SEND.
REQ-026 SEND: when tx_busy=0, pulse tx_en for 1 cycle and go to WAIT_TX; while tx_busy=1, hold in SEND.
REQ-027 WAIT_TX: on tx_done, go to IDLE.
REQ-028 Latency: the read-response tx_en asserts 3 cycles after the addr-byte rx_done, provided tx_busy=0.
REQ-029 Inter-byte timeout:
- The timeout counter clears on entry to GET_ADDR or GET_DATA and on every accepted byte.
- At TIMEOUT_CYCLES-1 with no rx_done, pulse err, go to IDLE, and issue no bus access and no response.
REQ-030 If rx_done coincides with the timeout cycle, the byte SHALL be accepted and the timeout ignored.
REQ-031 If rx_done arrives in BUS_WR, BUS_RD, RD_WAIT, SEND or WAIT_TX, the byte SHALL be dropped, err pulsed, and the state unchanged.
REQ-032 mem_we and mem_re SHALL never both be high, and SHALL never assert outside BUS_WR/BUS_RD.
REQ-033 mem_addr and mem_wdata SHALL hold their values until the next frame overwrites them.

Reset
REQ-034 While rst=1:
- State is IDLE.
- tx_data, mem_addr and mem_wdata are 0.
- tx_en, mem_we, mem_re, busy and err are 0.
- The timeout counter is 0.
REQ-035 Reset asserted mid-frame or mid-transmission SHALL abandon the frame with no further bus strobe or tx_en; a strobe already in flight is cut off asynchronously.

Verification
REQ-036 Write: bytes 0x57, 0x10, 0xA5 -> one mem_we with mem_addr=0x10, mem_wdata=0xA5; then tx_en with tx_data=0x4B.
REQ-037 Read: 0x52, 0x10 with a model returning 0xA5 -> mem_re 1 cycle after rx_done, tx_en with tx_data=0xA5 3 cycles after rx_done.
REQ-038 Bad opcode 0x00 -> err pulse, tx_data=0x3F sent, no mem_we/mem_re.
REQ-039 Timeout (TIMEOUT_CYCLES=100): send 0x57 then stop -> err exactly 100 cycles later, back in IDLE, no strobe; a following 0x52, 0x01 read completes normally.
REQ-040 Backpressure: tx_busy held high for 50 cycles -> tx_en delayed until tx_busy=0; a byte arriving during SEND is dropped with an err pulse.
REQ-041 Reset: assert rst between the 0x57 and 0x10 bytes -> all outputs 0 immediately, no later mem_we.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Byte-oriented command parser between a UART and a simple memory bus.
// Frames: 0x57 addr data (write, answered 0x4B) and 0x52 addr (read, answered with the data).
module uart_cmd_parser #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    output logic [7:0]            tx_data,
    output logic                  tx_en,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  err
);

    localparam int         CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_NAK = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        RD_WAIT,
        SEND,
        WAIT_TX
    } state_t;

    state_t                  state_q;
    logic                    opc_wr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [7:0]              tx_data_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [7:0]              mem_wdata_q;
    logic                    mem_we_q;
    logic                    mem_re_q;
    logic                    err_q;
    logic                    waiting_byte;
    logic                    timeout;

    assign waiting_byte = (state_q == GET_ADDR) || (state_q == GET_DATA);
    // A byte landing in the last allowed cycle wins over the timeout.
    assign timeout      = waiting_byte && !rx_done && (cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            opc_wr_q    <= 1'b0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_done) begin
                        if (rx_data == OP_WR || rx_data == OP_RD) begin
                            opc_wr_q <= (rx_data == OP_WR);
                            cnt_q    <= '0;
                            state_q  <= GET_ADDR;
                        end else begin
                            tx_data_q <= RSP_NAK;
                            err_q     <= 1'b1;
                            state_q   <= SEND;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_done) begin
                        mem_addr_q <= ADDR_WIDTH'(rx_data);
                        cnt_q      <= '0;
                        if (opc_wr_q) begin
                            state_q <= GET_DATA;
                        end else begin
                            mem_re_q <= 1'b1;
                            state_q  <= BUS_RD;
                        end
                    end else if (timeout) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GET_DATA: begin
                    if (rx_done) begin
                        mem_wdata_q <= rx_data;
                        cnt_q       <= '0;
                        mem_we_q    <= 1'b1;
                        state_q     <= BUS_WR;
                    end else if (timeout) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BUS_WR: begin
                    tx_data_q <= RSP_ACK;
                    state_q   <= SEND;
                end
                BUS_RD: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    tx_data_q <= mem_rdata;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        state_q <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // Bytes arriving while a command is executing are discarded.
            if (rx_done && !(state_q inside {IDLE, GET_ADDR, GET_DATA})) begin
                err_q <= 1'b1;
            end
        end
    end

    // tx_en is decoded from SEND so the response leaves in the SEND cycle itself.
    assign tx_en     = (state_q == SEND) && !tx_busy;
    assign tx_data   = tx_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q | timeout;

endmodule
